// File: rtl/msrv32_muldiv_unit.sv
// RV32M multiply/divide unit: iterative radix-2 shift-add multiplier and
// restoring divider sharing one 2*WIDTH working register. Divide-by-zero and
// signed overflow complete without iterating.
//
// Handshake: a request is taken on a rising edge where valid_in & ready_out &
// !flush_in; the result is handed over on a rising edge where valid_out &
// ready_in. valid_out/result_out hold steady until then. flush_in drops any
// in-flight operation. ready_out is only high in IDLE, so accepts are never
// back to back.
module msrv32_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             ms_riscv32_mp_clk_in,
  input  logic             ms_riscv32_mp_rst_n_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic [2:0]       opcode_in,
  input  logic [WIDTH-1:0] op_1_in,
  input  logic [WIDTH-1:0] op_2_in,
  input  logic             flush_in,
  output logic             valid_out,
  input  logic             ready_in,
  output logic [WIDTH-1:0] result_out,
  output logic             busy_out,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t               state, next_state;
  logic [CNT_W-1:0]     cnt_q;
  logic [2:0]           op_q;
  logic                 neg_a_q, neg_b_q;
  logic [WIDTH-1:0]     operand_q;
  logic [2*WIDTH-1:0]   prod_q;
  logic [WIDTH-1:0]     result_q;

  logic                 accept, is_div, sign_1, sign_2, neg_1, neg_2;
  logic [WIDTH-1:0]     mag_1, mag_2, special_result;
  logic                 div_zero, div_ovf, last;
  logic [WIDTH:0]       mul_sum, rem_shift, rem_diff;
  logic                 q_bit;
  logic [2*WIDTH-1:0]   mul_next, div_next, step_next, prod_signed;
  logic [WIDTH-1:0]     quot, rem, mul_result, div_result, final_result;

  // Request decode: operand signedness, magnitudes and the non-iterating cases
  always_comb begin
    accept   = valid_in & (state == IDLE) & ~flush_in;
    is_div   = opcode_in[2];
    sign_1   = is_div ? ~opcode_in[0] : (opcode_in[1:0] == 2'b01 || opcode_in[1:0] == 2'b10);
    sign_2   = is_div ? ~opcode_in[0] : (opcode_in[1:0] == 2'b01);
    neg_1    = sign_1 & op_1_in[WIDTH-1];
    neg_2    = sign_2 & op_2_in[WIDTH-1];
    mag_1    = neg_1 ? -op_1_in : op_1_in;
    mag_2    = neg_2 ? -op_2_in : op_2_in;
    div_zero = is_div & (op_2_in == '0);
    div_ovf  = is_div & ~opcode_in[0] & (op_1_in == SMIN) & (op_2_in == '1);
    special_result = '0;
    if (div_zero) special_result = opcode_in[1] ? op_1_in : '1;
    else          special_result = opcode_in[1] ? '0 : op_1_in;
  end

  // One radix-2 step of either algorithm, plus sign fix-up of the final step
  always_comb begin
    last      = (cnt_q == CNT_W'(WIDTH-1));
    mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, operand_q} : '0);
    mul_next  = {mul_sum, prod_q[WIDTH-1:1]};
    rem_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, operand_q};
    q_bit     = ~rem_diff[WIDTH];
    div_next  = {(q_bit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0]), prod_q[WIDTH-2:0], q_bit};
    step_next = op_q[2] ? div_next : mul_next;
    prod_signed = (neg_a_q ^ neg_b_q) ? -mul_next : mul_next;
    mul_result  = (op_q[1:0] == 2'b00) ? prod_signed[WIDTH-1:0] : prod_signed[2*WIDTH-1:WIDTH];
    quot        = div_next[WIDTH-1:0];
    rem         = div_next[2*WIDTH-1:WIDTH];
    div_result  = op_q[1] ? (neg_a_q ? -rem : rem) : ((neg_a_q ^ neg_b_q) ? -quot : quot);
    final_result = op_q[2] ? div_result : mul_result;
  end

  // State register
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) state <= IDLE;
    else                         state <= next_state;
  end

  // Next-state and handshake outputs
  always_comb begin
    next_state = state;
    ready_out  = 1'b0;
    valid_out  = 1'b0;
    busy_out   = 1'b0;
    result_out = '0;
    fsm_state  = state;
    case (state)
      IDLE: begin
        ready_out = 1'b1;
        if (accept) next_state = (div_zero | div_ovf) ? DONE : CALC;
      end
      CALC: begin
        busy_out = 1'b1;
        if (flush_in)  next_state = IDLE;
        else if (last) next_state = DONE;
      end
      DONE: begin
        busy_out   = 1'b1;
        valid_out  = 1'b1;
        result_out = result_q;
        if (flush_in | ready_in) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, iterate in CALC, capture the result
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      cnt_q     <= '0;
      op_q      <= '0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      operand_q <= '0;
      prod_q    <= '0;
      result_q  <= '0;
    end else if (accept) begin
      cnt_q     <= '0;
      op_q      <= opcode_in;
      neg_a_q   <= neg_1;
      neg_b_q   <= neg_2;
      operand_q <= is_div ? mag_2 : mag_1;
      prod_q    <= {{WIDTH{1'b0}}, (is_div ? mag_1 : mag_2)};
      result_q  <= (div_zero | div_ovf) ? special_result : '0;
    end else if (state == CALC) begin
      prod_q <= step_next;
      cnt_q  <= cnt_q + CNT_W'(1);
      if (last) result_q <= final_result;
    end
  end

endmodule
